serial_adder: RTL and testbench

//  Bit-serial N-bit adder built around the team's one-bit sum/carry stage.
//  - Operands are accepted through a valid/ready handshake.
//  - One bit is added per clock, LSB first, with the carry held in a register

---
 rtl/serial_adder.sv | 137 +++++++++++++
 tb/tb_serial_adder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder with valid/ready operand and result handshakes
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             done_valid,
  input  logic             done_ready
);

  // Bit counter needs at least one bit even when WIDTH is 1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_sum;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] s_msb;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             ha0_s;
  logic             ha0_c;
  logic             ha1_s;
  logic             ha1_c;
  logic             carry_next;
  logic             start_fire;
  logic             last_bit;

  // One-bit sum/carry stage: two cascaded half adders, carries merged by an OR.
  always_comb begin
    ha0_s      = sh_a[0] ^ sh_b[0];
    ha0_c      = sh_a[0] & sh_b[0];
    ha1_s      = ha0_s ^ carry;
    ha1_c      = ha0_s & carry;
    carry_next = ha0_c | ha1_c;
  end

  // New sum bit enters at the MSB so the LSB-first result ends up aligned after WIDTH shifts.
  always_comb begin
    s_msb            = '0;
    s_msb[WIDTH-1]   = ha1_s;
    sum_next         = (sh_sum >> 1) | s_msb;
  end

  assign start_fire = start_valid & start_ready;
  assign last_bit   = (cnt == LAST);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_fire) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    if (done_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: operands are accepted only while idle.
  always_comb begin
    start_ready = (state == IDLE);
  end

  // Datapath: operand load, per-bit shift/accumulate, and registered result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_a       <= '0;
      sh_b       <= '0;
      sh_sum     <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
      Sum        <= '0;
      Cout       <= 1'b0;
      done_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_fire) begin
            sh_a   <= A;
            sh_b   <= B;
            carry  <= Cin;
            cnt    <= '0;
            sh_sum <= '0;
          end
        end
        RUN: begin
          sh_a   <= sh_a >> 1;
          sh_b   <= sh_b >> 1;
          carry  <= carry_next;
          sh_sum <= sum_next;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            Sum        <= sum_next;
            Cout       <= carry_next;
            done_valid <= 1'b1;
          end
        end
        DONE: begin
          if (done_ready) begin
            done_valid <= 1'b0;
          end
        end
        default: begin
          done_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=8 and WIDTH=1)
module tb_serial_adder;

  logic       clk;
  logic       reset;

  logic       start_valid;
  logic       start_ready;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic [7:0] Sum;
  logic       Cout;
  logic       done_valid;
  logic       done_ready;

  logic       sv1;
  logic       sr1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       c1;
  logic [0:0] sum1;
  logic       cout1;
  logic       dv1;
  logic       dr1;

  int passed;
  int total;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[9];

  serial_adder #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .A           (A),
    .B           (B),
    .Cin         (Cin),
    .Sum         (Sum),
    .Cout        (Cout),
    .done_valid  (done_valid),
    .done_ready  (done_ready)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk         (clk),
    .reset       (reset),
    .start_valid (sv1),
    .start_ready (sr1),
    .A           (a1),
    .B           (b1),
    .Cin         (c1),
    .Sum         (sum1),
    .Cout        (cout1),
    .done_valid  (dv1),
    .done_ready  (dr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive operands, complete the handshake, and count edges until done_valid.
  task automatic start_and_wait(input logic [7:0] a, input logic [7:0] b, input logic c,
                                input bit sync, output int lat);
    int guard;
    if (sync) @(negedge clk);
    guard = 0;
    while (!start_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("start_ready_before_op", start_ready, 1);
    A = a;
    B = b;
    Cin = c;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    A = 8'h00;
    B = 8'h00;
    Cin = 1'b0;
    lat = 0;
    while (!done_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_done(input int hold);
    for (int i = 0; i < hold; i++) @(posedge clk);
    @(negedge clk);
    done_ready = 1'b1;
    @(posedge clk);
    #1;
    done_ready = 1'b0;
    check("done_valid_cleared", done_valid, 0);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] exp_s, input logic exp_c, input int hold);
    int lat;
    start_and_wait(a, b, c, 1'b1, lat);
    check("latency", lat, 8);
    check("sum", Sum, exp_s);
    check("cout", Cout, exp_c);
    release_done(hold);
  endtask

  initial begin
    int          lat;
    bit          saw_done;
    logic [8:0]  model;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rc;
    logic [1:0]  tt[8];
    logic [2:0]  idx;

    passed = 0;
    total  = 0;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[8] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};

    tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    reset       = 1'b1;
    start_valid = 1'b0;
    A           = 8'h00;
    B           = 8'h00;
    Cin         = 1'b0;
    done_ready  = 1'b0;
    sv1         = 1'b0;
    a1          = 1'b0;
    b1          = 1'b0;
    c1          = 1'b0;
    dr1         = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_sum", Sum, 0);
    check("rst_cout", Cout, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_start_ready", start_ready, 1);
    check("rst_w1_start_ready", sr1, 1);
    check("rst_w1_done_valid", dv1, 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, i % 3);
    end

    // Result held under backpressure while start pulses are ignored
    start_and_wait(8'h12, 8'h34, 1'b1, 1'b1, lat);
    check("bp_latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      A = 8'hFF;
      B = 8'hFF;
      Cin = 1'b1;
      start_valid = 1'b1;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      check("bp_sum_stable", Sum, 8'h47);
      check("bp_cout_stable", Cout, 0);
      check("bp_done_valid_stable", done_valid, 1);
      check("bp_start_ready_low", start_ready, 0);
    end
    release_done(0);
    check("bp_idle_after_release", start_ready, 1);
    run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 0);

    // Reset in the middle of an operation
    @(negedge clk);
    A = 8'hAA;
    B = 8'h55;
    Cin = 1'b0;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_sum", Sum, 0);
    check("abort_cout", Cout, 0);
    check("abort_done_valid", done_valid, 0);
    check("abort_start_ready", start_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    start_and_wait(8'h01, 8'h01, 1'b0, 1'b0, lat);
    check("abort_next_latency", lat, 8);
    check("abort_next_sum", Sum, 8'h02);
    check("abort_next_cout", Cout, 0);
    release_done(1);
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done_valid) saw_done = 1'b1;
    end
    check("no_spurious_done", saw_done, 0);

    // Randomized operations with random backpressure
    for (int i = 0; i < 500; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      model = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      run_op(ra, rb, rc, model[7:0], model[8], $urandom_range(0, 3));
    end

    // WIDTH=1 full-adder truth table
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      @(negedge clk);
      check("w1_start_ready", sr1, 1);
      a1 = idx[2];
      b1 = idx[1];
      c1 = idx[0];
      sv1 = 1'b1;
      @(posedge clk);
      #1;
      sv1 = 1'b0;
      check("w1_busy_after_handshake", sr1, 0);
      @(posedge clk);
      #1;
      check("w1_done_after_one_edge", dv1, 1);
      check("w1_result", {cout1, sum1}, tt[i]);
      @(negedge clk);
      dr1 = 1'b1;
      @(posedge clk);
      #1;
      dr1 = 1'b0;
      check("w1_done_cleared", dv1, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
